scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Controller that drives one `address_generator` instance through a 2-D tile scan.
- Each row: `rows` rows of (`last_col`+1) consecutive addresses; the base advances by `stride` at each row end.
- Sits between the layer control FSM (start/done handshake) and a memory read port (valid/ready address stream).
- Owns every control input of the generator; reads back `offset_co`, `offset` and `base_reg_out`.

Parameters:
- CELL_COUNT, 2048, memory depth addressed by the generator
- MAX_OFFSET, 16, generator offset range
- MAX_ROWS, 256, maximum rows per scan
- OFFSET_WIDTH, $clog2(MAX_OFFSET), offset/column width
- ADDR_WIDTH, $clog2(CELL_COUNT), address width
- ROW_WIDTH, $clog2(MAX_ROWS)+1, row count width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel
- cfg_base  in  ADDR_WIDTH  first address of tile
- cfg_stride  in  ADDR_WIDTH  base increment per row
- cfg_last_col  in  OFFSET_WIDTH  columns-1
- cfg_rows  in  ROW_WIDTH  row count; 0 = empty scan
- busy  out  1  high from LOAD through last accepted address
- done  out  1  one-cycle pulse at scan completion
- addr_valid  out  1  generator address presented to memory
- addr_ready  in  1  memory accepts address
- row_idx  out  ROW_WIDTH  current row index
- ag_offset_rst  out  1  to generator `offset_rst`
- ag_offset_upcount  out  1  to `offset_upcount`; constant 1
- ag_offset_cen  out  1  to `offset_cen`
- ag_offset_max_count  out  OFFSET_WIDTH  to `offset_max_count`
- ag_base_reg_rst  out  1  to `base_reg_rst`
- ag_base_init  out  ADDR_WIDTH  to `base_reg_init_value`
- ag_base_in  out  ADDR_WIDTH  to `base_reg_in`
- ag_offset_co  in  1  from generator `offset_co`
- ag_base_out  in  ADDR_WIDTH  from generator `base_reg_out`

Behaviour:
- Reset (rst=0), all outputs:
  - state=IDLE; busy=0; done=0; addr_valid=0; row_idx=0; ag_offset_cen=0; ag_offset_rst=1; ag_base_reg_rst=1; ag_offset_upcount=1.
  - Latched cfg registers = 0.
- IDLE:
  - ag_offset_rst=ag_base_reg_rst=0.
  - start=1 with cfg_rows!=0: latch cfg_base, cfg_stride, cfg_last_col, cfg_rows; go to LOAD.
  - start=1 with cfg_rows==0: go to DONE; no addresses issued.
- LOAD (1 cycle):
  - ag_offset_rst=1 and ag_base_reg_rst=1, so the generator loads base=cfg_base and offset=0.
  - busy=1; row_idx=0; go to SCAN.
- SCAN:
  - addr_valid=1; busy=1.
  - ag_offset_cen = addr_ready, so the offset advances only on an accepted address.
  - Accept with ag_offset_co=1 ends a row:
    - The generator loads base = ag_base_in, with ag_base_in = ag_base_out + stride modulo 2^ADDR_WIDTH, combinational.
    - Offset wraps to 0; row_idx increments.
    - If row_idx == rows-1: go to DONE. Otherwise stay in SCAN with no bubble.
  - addr_ready=0: hold every control; ag_offset_cen=0; address stable.
- DONE (1 cycle): done=1, busy=0, addr_valid=0; go to IDLE.
- Throughput and latency:
  - 1 address/cycle under continuous ready.
  - First addr_valid 2 cycles after start.
  - done one cycle after the last accepted address.
- ag_offset_max_count = latched cfg_last_col. ag_base_init = latched cfg_base.
- Address arithmetic wraps modulo CELL_COUNT: base 2040 + stride 16 gives 8. No error flag.
- abort=1 in any state except IDLE:
  - Next state IDLE; ag_offset_rst=1 and ag_base_reg_rst=1 for that cycle.
  - No done pulse; addr_valid drops the cycle after abort.
  - abort has priority over start and over accept.
- start outside IDLE is ignored and not queued.
- cfg_* inputs change mid-scan: no effect; latched values are used.

Optional Feature:
- Macro: SCAN_STALL_COUNTER_EN.
- When defined:
  - Adds output `stall_cycles` (width 16), counting SCAN cycles with addr_ready=0.
  - Cleared in LOAD and saturates at 0xFFFF.
  - Holds its value after DONE until the next LOAD; reset value 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- base=100, stride=32, last_col=3, rows=2, ready=1:
  - Addresses 100,101,102,103,132,133,134,135 on consecutive cycles.
  - row_idx 0→1 after 103; done pulses 1 cycle after 135.
- Same config, ready low on 2nd and 6th cycles:
  - Same address sequence; each stalled address held stable.
  - Total SCAN cycles=10; stall_cycles=2 when SCAN_STALL_COUNTER_EN is defined.
- base=2040, stride=16, last_col=15, rows=2:
  - Row 0 = 2040..2047,0..7; row 1 starts at 8 and ends at 23.
- cfg_rows=0 with start: DONE next cycle; addr_valid never 1; busy stays 0.
- abort during row 1 of a rows=4 scan:
  - addr_valid=0 next cycle; no done; IDLE.
  - A following start with base=5 issues 5 first.
- start pulsed in SCAN with a different cfg: ignored; original sequence and single done unchanged.
- rst asserted mid-scan: all outputs at reset values immediately (async); IDLE after release.

Source files
------------

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 2-D tile scan controller driving one address_generator
//
// Walks `rows` rows of (last_col+1) consecutive addresses, advancing the
// generator base by `stride` at every row end, and presents each generator
// address on a valid/ready stream to a memory read port.
//
// Optional build macro: SCAN_STALL_COUNTER_EN adds the stall_cycles output.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, abort        scan request (IDLE only) / synchronous cancel
//   cfg_base            first address of the tile
//   cfg_stride          base increment per row
//   cfg_last_col        columns per row minus one
//   cfg_rows            row count, 0 = empty scan
//   busy, done          LOAD..last accept / one-cycle completion pulse
//   addr_valid          generator address presented to memory
//   addr_ready          memory accepts the address
//   row_idx             current row index
//   ag_*                control outputs to / readback from the generator
//   stall_cycles        (SCAN_STALL_COUNTER_EN only) SCAN cycles with addr_ready=0

module scan_sequencer #(
  parameter int CELL_COUNT   = 2048,
  parameter int MAX_OFFSET   = 16,
  parameter int MAX_ROWS     = 256,
  parameter int OFFSET_WIDTH = $clog2(MAX_OFFSET),
  parameter int ADDR_WIDTH   = $clog2(CELL_COUNT),
  parameter int ROW_WIDTH    = $clog2(MAX_ROWS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_stride,
  input  logic [OFFSET_WIDTH-1:0] cfg_last_col,
  input  logic [ROW_WIDTH-1:0]    cfg_rows,
  output logic                    busy,
  output logic                    done,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [ROW_WIDTH-1:0]    row_idx,
  output logic                    ag_offset_rst,
  output logic                    ag_offset_upcount,
  output logic                    ag_offset_cen,
  output logic [OFFSET_WIDTH-1:0] ag_offset_max_count,
  output logic                    ag_base_reg_rst,
  output logic [ADDR_WIDTH-1:0]   ag_base_init,
  output logic [ADDR_WIDTH-1:0]   ag_base_in,
  input  logic                    ag_offset_co,
  input  logic [ADDR_WIDTH-1:0]   ag_base_out
`ifdef SCAN_STALL_COUNTER_EN
  ,
  output logic [15:0]             stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   stride_q;
  logic [OFFSET_WIDTH-1:0] last_col_q;
  logic [ROW_WIDTH-1:0]    rows_q;
  logic [ROW_WIDTH-1:0]    row_q;

  logic abort_act;
  logic accept;
  logic row_end;
  logic last_row;
  logic cfg_load;

  // abort is meaningless in IDLE; everywhere else it beats start and accept.
  assign abort_act = abort && (state_q != S_IDLE);
  assign accept    = (state_q == S_SCAN) && addr_ready && !abort_act;
  assign row_end   = accept && ag_offset_co;
  assign last_row  = (row_q == (rows_q - ROW_WIDTH'(1)));
  assign cfg_load  = (state_q == S_IDLE) && start && (cfg_rows != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_rows != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: state_d = S_SCAN;
      S_SCAN: begin
        if (row_end && last_row) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_act) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      stride_q   <= '0;
      last_col_q <= '0;
      rows_q     <= '0;
    end else if (cfg_load) begin
      base_q     <= cfg_base;
      stride_q   <= cfg_stride;
      last_col_q <= cfg_last_col;
      rows_q     <= cfg_rows;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
    end else if (state_q == S_LOAD && !abort_act) begin
      row_q <= '0;
    end else if (row_end) begin
      row_q <= row_q + ROW_WIDTH'(1);
    end
  end

  // The generator reset strobes are also forced while rst is low so the
  // generator sits in its reset state together with this controller.
  always_comb begin
    busy            = (state_q == S_LOAD) || (state_q == S_SCAN);
    done            = (state_q == S_DONE) && !abort_act;
    addr_valid      = (state_q == S_SCAN);
    ag_offset_cen   = accept;
    ag_offset_rst   = !rst || (state_q == S_LOAD) || abort_act;
    ag_base_reg_rst = !rst || (state_q == S_LOAD) || abort_act;
  end

  assign row_idx             = row_q;
  assign ag_offset_upcount   = 1'b1;
  assign ag_offset_max_count = last_col_q;
  assign ag_base_init        = base_q;
  // Wraps modulo 2^ADDR_WIDTH by truncation.
  assign ag_base_in          = ag_base_out + stride_q;

`ifdef SCAN_STALL_COUNTER_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (state_q == S_LOAD) begin
      stall_q <= '0;
    end else if (state_q == S_SCAN && !addr_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer
module tb_scan_sequencer;

  localparam int AW = 11;
  localparam int OW = 4;
  localparam int RW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [AW-1:0] cfg_base, cfg_stride;
  logic [OW-1:0] cfg_last_col;
  logic [RW-1:0] cfg_rows;
  logic          busy, done, addr_valid, ready;
  logic [RW-1:0] row_idx;
  logic          ag_offset_rst, ag_offset_upcount, ag_offset_cen, ag_base_reg_rst;
  logic [OW-1:0] ag_offset_max_count;
  logic [AW-1:0] ag_base_init, ag_base_in, ag_base_out;
  logic          ag_offset_co;
`ifdef SCAN_STALL_COUNTER_EN
  logic [15:0]   stall_cycles;
`endif

  scan_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_last_col(cfg_last_col), .cfg_rows(cfg_rows),
    .busy(busy), .done(done), .addr_valid(addr_valid), .addr_ready(ready), .row_idx(row_idx),
    .ag_offset_rst(ag_offset_rst), .ag_offset_upcount(ag_offset_upcount), .ag_offset_cen(ag_offset_cen),
    .ag_offset_max_count(ag_offset_max_count), .ag_base_reg_rst(ag_base_reg_rst),
    .ag_base_init(ag_base_init), .ag_base_in(ag_base_in),
    .ag_offset_co(ag_offset_co), .ag_base_out(ag_base_out)
`ifdef SCAN_STALL_COUNTER_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Address generator: base register plus wrapping offset counter.
  logic [OW-1:0] g_off;
  logic [AW-1:0] g_base;
  logic [AW-1:0] gen_addr;
  assign ag_offset_co = (g_off == ag_offset_max_count);
  assign ag_base_out  = g_base;
  assign gen_addr     = g_base + AW'(g_off);

  always_ff @(posedge clk) begin
    if (ag_offset_rst) g_off <= '0;
    else if (ag_offset_cen) g_off <= ag_offset_co ? '0 : g_off + OW'(1);
    if (ag_base_reg_rst) g_base <= ag_base_init;
    else if (ag_offset_cen && ag_offset_co) g_base <= ag_base_in;
  end

  int total = 0;
  int bad = 0;

  int got[$];
  int scan_cyc, done_cnt, done_k, first_k, last_acc_k, busy_cyc;
  int hold_bad, row_bad, valid_after_abort, abort_rst_ok, timed_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int exp_addr(input int b, input int s, input int lc, input int i);
    return (b + (i / (lc + 1)) * s + (i % (lc + 1))) % 2048;
  endfunction

  // mode: 0 always ready, 1 ready low on 2nd and 6th SCAN cycles, 2 random ready
  task automatic run_scan(input int b, input int s, input int lc, input int r,
                          input int mode, input int abort_sc, input int mstart_sc);
    int k, sc, acc, held, have_held, abort_k;
    got.delete();
    scan_cyc = 0; done_cnt = 0; done_k = -1; first_k = -1; last_acc_k = -1;
    busy_cyc = 0; hold_bad = 0; row_bad = 0; valid_after_abort = 0;
    abort_rst_ok = 0; timed_out = 1;
    sc = 0; acc = 0; held = 0; have_held = 0; abort_k = -1;
    cfg_base = AW'(b); cfg_stride = AW'(s); cfg_last_col = OW'(lc); cfg_rows = RW'(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 1; k < 300; k++) begin
      case (mode)
        1:       ready = !((sc + 1) == 2 || (sc + 1) == 6);
        2:       ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
      abort = (abort_sc >= 0 && sc == abort_sc && abort_k < 0);
      if (mstart_sc >= 0 && sc == mstart_sc && addr_valid) begin
        start = 1'b1;
        cfg_base = AW'(b + 7); cfg_stride = AW'(s + 3);
        cfg_last_col = OW'(lc + 1); cfg_rows = RW'(r + 2);
      end
      @(negedge clk);
      if (busy) busy_cyc++;
      if (addr_valid) begin
        if (first_k < 0) first_k = k;
        sc++;
        scan_cyc++;
        if (have_held && int'(gen_addr) != held) hold_bad++;
        have_held = 0;
        if (ready && !abort) begin
          got.push_back(int'(gen_addr));
          if (int'(row_idx) != acc / (lc + 1)) row_bad++;
          acc++;
          last_acc_k = k;
        end else if (!ready) begin
          held = int'(gen_addr);
          have_held = 1;
        end
      end
      if (abort_k >= 0 && k == abort_k + 1 && addr_valid) valid_after_abort++;
      if (abort) begin
        abort_k = k;
        abort_rst_ok = (ag_offset_rst && ag_base_reg_rst) ? 1 : 0;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (done_cnt > 0 && k >= done_k + 2) begin timed_out = 0; break; end
      if (abort_k >= 0 && k >= abort_k + 4) begin timed_out = 0; break; end
    end
    ready = 1'b0;
  endtask

  task automatic check_run(input string tag, input int b, input int s, input int lc, input int r);
    int addr_bad;
    addr_bad = 0;
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_count"}, got.size(), r * (lc + 1));
    foreach (got[i]) if (got[i] != exp_addr(b, s, lc, i)) addr_bad++;
    chk({tag, "_addr_bad"}, addr_bad, 0);
    chk({tag, "_row_bad"}, row_bad, 0);
    chk({tag, "_hold_bad"}, hold_bad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (r > 0) begin
      chk({tag, "_first_valid"}, first_k, 2);
      chk({tag, "_done_lat"}, done_k, last_acc_k + 1);
      chk({tag, "_busy"}, busy_cyc, scan_cyc + 1);
    end else begin
      chk({tag, "_done_lat"}, done_k, 1);
      chk({tag, "_no_valid"}, first_k, -1);
      chk({tag, "_busy"}, busy_cyc, 0);
    end
`ifdef SCAN_STALL_COUNTER_EN
    if (r > 0) chk({tag, "_stalls"}, stall_cycles, scan_cyc - got.size());
`endif
  endtask

  initial begin
    int b, s, lc, r;
    rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_last_col = '0; cfg_rows = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_cen", ag_offset_cen, 0);
    chk("rst_offrst", ag_offset_rst, 1);
    chk("rst_baserst", ag_base_reg_rst, 1);
    chk("rst_upcount", ag_offset_upcount, 1);
    chk("rst_init", ag_base_init, 0);
    chk("rst_maxcnt", ag_offset_max_count, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_offrst", ag_offset_rst, 0);
    chk("idle_baserst", ag_base_reg_rst, 0);

    run_scan(100, 32, 3, 2, 0, -1, -1);
    check_run("basic", 100, 32, 3, 2);
    chk("basic_scan_cyc", scan_cyc, 8);

    run_scan(100, 32, 3, 2, 1, -1, -1);
    check_run("stall", 100, 32, 3, 2);
    chk("stall_scan_cyc", scan_cyc, 10);
`ifdef SCAN_STALL_COUNTER_EN
    chk("stall_counter", stall_cycles, 2);
`endif

    run_scan(2040, 16, 15, 2, 0, -1, -1);
    check_run("wrap", 2040, 16, 15, 2);
    chk("wrap_row1_first", got[16], 8);
    chk("wrap_row1_last", got[31], 23);

    run_scan(100, 32, 3, 0, 0, -1, -1);
    check_run("empty", 100, 32, 3, 0);

    run_scan(200, 10, 3, 4, 0, 6, -1);
    chk("abort_timeout", timed_out, 0);
    chk("abort_count", got.size(), 6);
    chk("abort_valid_next", valid_after_abort, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_gen_rst", abort_rst_ok, 1);
    chk("abort_busy_after", busy, 0);

    run_scan(5, 9, 2, 1, 0, -1, -1);
    check_run("after_abort", 5, 9, 2, 1);
    chk("after_abort_first", got[0], 5);

    run_scan(100, 32, 3, 2, 0, -1, 3);
    check_run("mid_start", 100, 32, 3, 2);

    for (int it = 0; it < 6; it++) begin
      b = int'($urandom_range(0, 2047));
      s = int'($urandom_range(0, 2047));
      lc = int'($urandom_range(0, 15));
      r = int'($urandom_range(1, 5));
      run_scan(b, s, lc, r, 2, -1, -1);
      check_run("random", b, s, lc, r);
    end

    // Asynchronous reset in the middle of a scan.
    cfg_base = AW'(50); cfg_stride = AW'(20); cfg_last_col = OW'(7); cfg_rows = RW'(3);
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_valid", addr_valid, 1);
    rst = 1'b0;
    #1;
    chk("arst_valid", addr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_row", row_idx, 0);
    chk("arst_cen", ag_offset_cen, 0);
    chk("arst_offrst", ag_offset_rst, 1);
    chk("arst_baserst", ag_base_reg_rst, 1);
    @(negedge clk);
    rst = 1'b1;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_valid", addr_valid, 0);
    @(posedge clk); #1;

    run_scan(300, 40, 1, 3, 0, -1, -1);
    check_run("post_rst", 300, 40, 1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
